// File: rtl/aes_key_expand_seq_if.sv
// Handshake bundle for the sequential AES-128 key expansion engine.
// slave = the engine, master = whoever starts expansions and consumes round keys.
interface aes_key_expand_seq_if;
    logic         start_i;
    logic [127:0] key_i;
    logic         busy_o;
    logic         rk_valid_o;
    logic         rk_ready_i;
    logic [127:0] rk_o;
    logic [3:0]   rk_idx_o;
    logic [7:0]   rcon_o;
    logic         done_o;
    logic [127:0] last_key_o;
    logic [7:0]   last_rcon_o;

    modport master (
        output start_i, key_i, rk_ready_i,
        input  busy_o, rk_valid_o, rk_o, rk_idx_o, rcon_o, done_o, last_key_o, last_rcon_o
    );

    modport slave (
        input  start_i, key_i, rk_ready_i,
        output busy_o, rk_valid_o, rk_o, rk_idx_o, rcon_o, done_o, last_key_o, last_rcon_o
    );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Forward AES-128 key expansion: streams round keys 0..10 over a valid/ready handshake
// and retains the round-10 key and its Rcon for seeding an inverse scheduler.
module aes_key_expand_seq (
    input  logic                       clk,
    input  logic                       rst_n,
    aes_key_expand_seq_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    // FIPS-197 S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // ~{x,3'b000} == 2047 - 8*x, the MSB of entry x
        return SBOX_TBL[~{x, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       state_q, state_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [7:0]   nrcon_q, nrcon_d;
    logic         done_q, done_d;
    logic [127:0] last_key_q, last_key_d;
    logic [7:0]   last_rcon_q, last_rcon_d;

    // One key-schedule round, purely combinational from the current round key.
    logic [31:0]  temp, w0_n, w1_n, w2_n, w3_n;
    logic [127:0] rk_next;

    assign temp    = sub_word({rk_q[23:0], rk_q[31:24]}) ^ {nrcon_q, 24'h000000};
    assign w0_n    = rk_q[127:96] ^ temp;
    assign w1_n    = rk_q[95:64]  ^ w0_n;
    assign w2_n    = rk_q[63:32]  ^ w1_n;
    assign w3_n    = rk_q[31:0]   ^ w2_n;
    assign rk_next = {w0_n, w1_n, w2_n, w3_n};

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        rk_d        = rk_q;
        idx_d       = idx_q;
        rcon_d      = rcon_q;
        nrcon_d     = nrcon_q;
        done_d      = 1'b0;
        last_key_d  = last_key_q;
        last_rcon_d = last_rcon_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    rk_d    = bus.key_i;
                    idx_d   = 4'd0;
                    rcon_d  = 8'h00;
                    nrcon_d = 8'h01;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (valid_q && bus.rk_ready_i) begin
                    if (idx_q < 4'd10) begin
                        rk_d    = rk_next;
                        idx_d   = idx_q + 4'd1;
                        rcon_d  = nrcon_q;
                        nrcon_d = xtime(nrcon_q);
                    end else begin
                        done_d      = 1'b1;
                        last_key_d  = rk_q;
                        last_rcon_d = 8'h36;
                        valid_d     = 1'b0;
                        busy_d      = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            rk_q        <= '0;
            idx_q       <= '0;
            rcon_q      <= '0;
            nrcon_q     <= 8'h01;
            done_q      <= 1'b0;
            last_key_q  <= '0;
            last_rcon_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            rk_q        <= rk_d;
            idx_q       <= idx_d;
            rcon_q      <= rcon_d;
            nrcon_q     <= nrcon_d;
            done_q      <= done_d;
            last_key_q  <= last_key_d;
            last_rcon_q <= last_rcon_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.rk_valid_o  = valid_q;
    assign bus.rk_o        = rk_q;
    assign bus.rk_idx_o    = idx_q;
    assign bus.rcon_o      = rcon_q;
    assign bus.done_o      = done_q;
    assign bus.last_key_o  = last_key_q;
    assign bus.last_rcon_o = last_rcon_q;
endmodule
